// File: rtl/wb_if.sv
// Writeback stage bus: ALU and load-unit result handshakes plus the register file write port.
// Optional bypass outputs (fwd_*) exist only when WB_BYPASS_EN is defined.
interface wb_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_result;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [XLEN-1:0]       mem_rdata;
    logic [2:0]            mem_funct3;
    logic [1:0]            mem_addr_lo;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [XLEN-1:0]       write_data;
    logic                  write_enable;
`ifdef WB_BYPASS_EN
    logic                  fwd_valid;
    logic [REG_ADDR_W-1:0] fwd_rd;
    logic [XLEN-1:0]       fwd_data;
`endif

    modport slave (
        input  alu_valid, alu_rd, alu_result,
        input  mem_valid, mem_rd, mem_rdata, mem_funct3, mem_addr_lo,
        output alu_ready, mem_ready, write_reg, write_data, write_enable
`ifdef WB_BYPASS_EN
        , output fwd_valid, fwd_rd, fwd_data
`endif
    );

    modport master (
        output alu_valid, alu_rd, alu_result,
        output mem_valid, mem_rd, mem_rdata, mem_funct3, mem_addr_lo,
        input  alu_ready, mem_ready, write_reg, write_data, write_enable
`ifdef WB_BYPASS_EN
        , input fwd_valid, fwd_rd, fwd_data
`endif
    );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: arbitrates ALU/load results into a two-phase (setup, strobe) register
// file write and formats load data. Define WB_BYPASS_EN to add the fwd_* bypass outputs.
module writeback_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input logic clk,
    input logic rst_n,
    wb_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, STROBE = 2'd2} state_t;

    state_t                state_r, state_s;
    logic                  pending_valid_r;
    logic [REG_ADDR_W-1:0] pending_rd_r;
    logic [XLEN-1:0]       pending_data_r;
    logic [REG_ADDR_W-1:0] write_reg_r;
    logic [XLEN-1:0]       write_data_r;
    logic                  write_enable_r;

    logic                  accept_ok_s, alu_ready_s, mem_ready_s, alu_fire_s, mem_fire_s;
    logic                  win_valid_s, load_s, pend_load_s, pend_take_s;
    logic [REG_ADDR_W-1:0] win_rd_s;
    logic [XLEN-1:0]       win_data_s;

    function automatic logic [XLEN-1:0] format_load(input logic [2:0] f3, input logic [1:0] lo,
                                                    input logic [XLEN-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lo, 3'b000} +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{(XLEN-8){b[7]}}, b};
            3'b001:  return {{(XLEN-16){h[15]}}, h};
            3'b100:  return {{(XLEN-8){1'b0}}, b};
            3'b101:  return {{(XLEN-16){1'b0}}, h};
            default: return w;
        endcase
    endfunction

    // Handshakes and winner selection: pending beats mem beats alu; nothing wins during SETUP.
    always_comb begin
        accept_ok_s = (state_r != SETUP);
        alu_ready_s = rst_n && !pending_valid_r;
        mem_ready_s = rst_n && accept_ok_s && !pending_valid_r;
        alu_fire_s  = bus.alu_valid && alu_ready_s;
        mem_fire_s  = bus.mem_valid && mem_ready_s;
        win_valid_s = 1'b0;
        win_rd_s    = {REG_ADDR_W{1'b0}};
        win_data_s  = {XLEN{1'b0}};
        if (accept_ok_s && pending_valid_r) begin
            win_valid_s = 1'b1;
            win_rd_s    = pending_rd_r;
            win_data_s  = pending_data_r;
        end else if (accept_ok_s && mem_fire_s) begin
            win_valid_s = 1'b1;
            win_rd_s    = bus.mem_rd;
            win_data_s  = format_load(bus.mem_funct3, bus.mem_addr_lo, bus.mem_rdata);
        end else if (accept_ok_s && alu_fire_s) begin
            win_valid_s = 1'b1;
            win_rd_s    = bus.alu_rd;
            win_data_s  = bus.alu_result;
        end else begin
            win_valid_s = 1'b0;
        end
        // An accepted ALU result that loses (SETUP cycle or mem won) parks in the pending slot.
        pend_load_s = alu_fire_s && (!accept_ok_s || mem_fire_s);
        pend_take_s = accept_ok_s && pending_valid_r;
    end

    // Next-state logic; a rd==0 winner is consumed without starting a write.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        case (state_r)
            IDLE, STROBE: begin
                if (win_valid_s && (win_rd_s != {REG_ADDR_W{1'b0}})) begin
                    state_s = SETUP;
                    load_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP:   state_s = STROBE;
            default: state_s = IDLE;
        endcase
    end

    // State, pending buffer and registered write-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            pending_valid_r <= 1'b0;
            pending_rd_r    <= {REG_ADDR_W{1'b0}};
            pending_data_r  <= {XLEN{1'b0}};
            write_reg_r     <= {REG_ADDR_W{1'b0}};
            write_data_r    <= {XLEN{1'b0}};
            write_enable_r  <= 1'b0;
        end else begin
            state_r        <= state_s;
            write_enable_r <= (state_s == STROBE);
            if (load_s) begin
                write_reg_r  <= win_rd_s;
                write_data_r <= win_data_s;
            end
            if (pend_load_s) begin
                pending_valid_r <= 1'b1;
                pending_rd_r    <= bus.alu_rd;
                pending_data_r  <= bus.alu_result;
            end else if (pend_take_s) begin
                pending_valid_r <= 1'b0;
            end
        end
    end

    assign bus.alu_ready    = alu_ready_s;
    assign bus.mem_ready    = mem_ready_s;
    assign bus.write_reg    = write_reg_r;
    assign bus.write_data   = write_data_r;
    assign bus.write_enable = write_enable_r;

`ifdef WB_BYPASS_EN
    logic fwd_valid_r;

    // Bypass is live while a write is in flight (SETUP or STROBE).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_valid_r <= 1'b0;
        end else begin
            fwd_valid_r <= (state_s != IDLE);
        end
    end

    assign bus.fwd_valid = fwd_valid_r;
    assign bus.fwd_rd    = write_reg_r;
    assign bus.fwd_data  = write_data_r;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// Directed and randomized bench for writeback_stage; expected writes come from a queue model
// that orders accepted results (mem before alu in the same cycle) and drops rd==0.
module tb_writeback_stage;
    localparam int XLEN = 32;
    localparam int RW   = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus ();
    writeback_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          strobes = 0;
    logic        prev_we = 1'b0;
    logic [31:0] prev_reg = 32'd0;
    logic [31:0] prev_data = 32'd0;
    logic        alu_acc = 1'b0;
    logic        mem_acc = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
        logic [31:0] byte_v, half_v;
        byte_v = (w >> (8 * lo)) & 32'hFF;
        half_v = (lo >= 2'd2) ? (w >> 16) : (w & 32'hFFFF);
        case (f3)
            3'd0:    return (byte_v >= 32'd128) ? byte_v - 32'd256 : byte_v;
            3'd1:    return (half_v >= 32'd32768) ? half_v - 32'd65536 : half_v;
            3'd4:    return byte_v;
            3'd5:    return half_v;
            default: return w;
        endcase
    endfunction

    // Scoreboard: checks each strobe against the model and records new acceptances.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.write_enable) begin
                strobes++;
                check("we_low_between", 32'(prev_we), 32'd0);
                check("reg_stable", 32'(bus.write_reg), prev_reg);
                check("data_stable", bus.write_data, prev_data);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(exp_q.size()), 32'd1);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write_reg", 32'(bus.write_reg), 32'(e.rd));
                    check("write_data", bus.write_data, e.data);
                end
            end
            mem_acc = bus.mem_valid && bus.mem_ready;
            alu_acc = bus.alu_valid && bus.alu_ready;
            if (mem_acc && bus.mem_rd != 5'd0)
                exp_q.push_back('{bus.mem_rd, ref_load(bus.mem_funct3, bus.mem_addr_lo, bus.mem_rdata)});
            if (alu_acc && bus.alu_rd != 5'd0)
                exp_q.push_back('{bus.alu_rd, bus.alu_result});
        end else begin
            mem_acc = 1'b0;
            alu_acc = 1'b0;
        end
        prev_we   = bus.write_enable;
        prev_reg  = 32'(bus.write_reg);
        prev_data = bus.write_data;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.alu_valid = v; bus.alu_rd = rd; bus.alu_result = d;
    endtask

    task automatic set_mem(input logic v, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] lo, input logic [31:0] w);
        bus.mem_valid = v; bus.mem_rd = rd; bus.mem_funct3 = f3; bus.mem_addr_lo = lo; bus.mem_rdata = w;
    endtask

    logic [2:0]  ld_f3  [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [1:0]  ld_lo  [4] = '{2'd3, 2'd3, 2'd2, 2'd0};
    logic [31:0] ld_exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};

    initial begin
        int base;
        int idx;
        logic acc;
        rst_n = 1'b0;
        set_alu(1'b0, 5'd0, 32'd0);
        set_mem(1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
        repeat (3) cyc();
        check("rst_write_reg", 32'(bus.write_reg), 32'd0);
        check("rst_write_data", bus.write_data, 32'd0);
        check("rst_write_enable", 32'(bus.write_enable), 32'd0);
        check("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
        check("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
        cyc();
        rst_n = 1'b1;

        // ALU only
        set_alu(1'b1, 5'd5, 32'hDEADBEEF);
        smp(); check("t1_alu_ready", 32'(bus.alu_ready), 32'd1);
        cyc(); set_alu(1'b0, 5'd0, 32'd0);
        smp(); check("t1_setup_reg", 32'(bus.write_reg), 32'd5);
        check("t1_setup_data", bus.write_data, 32'hDEADBEEF);
        check("t1_setup_we", 32'(bus.write_enable), 32'd0);
        smp(); check("t1_strobe_we", 32'(bus.write_enable), 32'd1);
        smp(); check("t1_after_we", 32'(bus.write_enable), 32'd0);

        // Simultaneous mem + alu
        cyc();
        set_mem(1'b1, 5'd3, 3'b010, 2'd0, 32'h11223344);
        set_alu(1'b1, 5'd4, 32'h000000A5);
        smp(); check("t2_mem_ready", 32'(bus.mem_ready), 32'd1);
        check("t2_alu_ready", 32'(bus.alu_ready), 32'd1);
        cyc(); set_mem(1'b0, 5'd0, 3'd0, 2'd0, 32'd0); set_alu(1'b0, 5'd0, 32'd0);
        smp(); check("t2_reg3", 32'(bus.write_reg), 32'd3);
        check("t2_data3", bus.write_data, 32'h11223344);
        check("t2_pend_alu_ready", 32'(bus.alu_ready), 32'd0);
        smp(); check("t2_we3", 32'(bus.write_enable), 32'd1);
        check("t2_pend_alu_ready2", 32'(bus.alu_ready), 32'd0);
        smp(); check("t2_we_gap", 32'(bus.write_enable), 32'd0);
        check("t2_reg4", 32'(bus.write_reg), 32'd4);
        check("t2_data4", bus.write_data, 32'h000000A5);
        check("t2_alu_ready_free", 32'(bus.alu_ready), 32'd1);
        smp(); check("t2_we4", 32'(bus.write_enable), 32'd1);
        smp();

        // Load formatting of 0x80FF7F01
        for (int i = 0; i < 4; i++) begin
            cyc(); set_mem(1'b1, 5'd9, ld_f3[i], ld_lo[i], 32'h80FF7F01);
            smp();
            cyc(); set_mem(1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
            smp(); check($sformatf("t3_load%0d", i), bus.write_data, ld_exp[i]);
            smp(); smp();
        end

        // rd == 0 is consumed without a write
        cyc(); set_alu(1'b1, 5'd0, 32'h00001234);
        smp(); check("t4_alu_ready", 32'(bus.alu_ready), 32'd1);
        cyc(); set_alu(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            smp(); check("t4_no_we", 32'(bus.write_enable), 32'd0);
            check("t4_idle_mem_ready", 32'(bus.mem_ready), 32'd1);
        end

        // Back-to-back ALU stream, valid held high
        cyc();
        base = strobes;
        idx = 0;
        set_alu(1'b1, 5'd1, $urandom);
        for (int n = 0; n < 22; n++) begin
            smp();
            acc = bus.alu_valid && bus.alu_ready;
            if (n == 19) check("t5_strobes9", 32'(strobes - base), 32'd9);
            if (n == 20) check("t5_strobes10", 32'(strobes - base), 32'd10);
            cyc();
            if (acc) begin
                idx++;
                if (idx < 10) set_alu(1'b1, 5'(idx + 1), $urandom);
                else set_alu(1'b0, 5'd0, 32'd0);
            end
        end
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset during STROBE with a result still pending
        set_mem(1'b1, 5'd3, 3'b010, 2'd0, 32'hCAFE0001);
        set_alu(1'b1, 5'd6, 32'h00000077);
        smp();
        cyc(); set_mem(1'b0, 5'd0, 3'd0, 2'd0, 32'd0); set_alu(1'b0, 5'd0, 32'd0);
        @(posedge clk); #2;
        check("t6_in_strobe", 32'(bus.write_enable), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_async_we_drop", 32'(bus.write_enable), 32'd0);
        check("t6_rst_alu_ready", 32'(bus.alu_ready), 32'd0);
        exp_q.delete();
        repeat (2) cyc();
        rst_n = 1'b1;
        base = strobes;
        repeat (8) smp();
        check("t6_no_stale_write", 32'(strobes - base), 32'd0);

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            cyc();
            if (!bus.alu_valid || alu_acc)
                set_alu(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
            if (!bus.mem_valid || mem_acc)
                set_mem(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                        3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom);
        end
        cyc();
        set_alu(1'b0, 5'd0, 32'd0);
        set_mem(1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
        repeat (12) smp();
        check("t7_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
